// File: rtl/wb_master_pkg.sv
// Shared opcodes, response constants and FSM encoding for the byte-stream
// Wishbone master.
package wb_master_pkg;

  localparam logic [3:0] OP_SETADDR = 4'h1;
  localparam logic [3:0] OP_WRITE   = 4'h2;
  localparam logic [3:0] OP_READ    = 4'h3;
  localparam logic [3:0] OP_PING    = 4'h4;
  localparam logic [3:0] OP_STATUS  = 4'h5;

  localparam logic [7:0] PING_RESP       = 8'hA5;
  localparam logic [7:0] RD_TIMEOUT_DATA = 8'hFF;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_ADDR0,
    ST_ADDR1,
    ST_ADDR2,
    ST_LEN,
    ST_WDATA,
    ST_WBUS,
    ST_RBUS,
    ST_TXWAIT
  } state_t;

  // States in which the host byte stream is allowed to advance.
  function automatic logic accepts_rx(state_t s);
    return s inside {ST_IDLE, ST_ADDR0, ST_ADDR1, ST_ADDR2, ST_LEN, ST_WDATA};
  endfunction

endpackage

// File: rtl/wb_timeout_counter.sv
// Ack-wait down-counter: loaded when a strobe starts, expires after
// timeout_cycles strobe cycles without an ack.
module wb_timeout_counter #(
  parameter int unsigned timeout_cycles = 255
) (
  input  logic clk,
  input  logic reset,
  input  logic load,
  input  logic run,
  output logic expired
);

  logic [7:0] cnt;

  // Reload at strobe start, count down while the strobe is held.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= 8'd0;
    end else if (load) begin
      cnt <= 8'(timeout_cycles - 1);
    end else if (run && cnt != 8'd0) begin
      cnt <= cnt - 8'd1;
    end
  end

  assign expired = (cnt == 8'd0);

endmodule

// File: rtl/wb_byte_master.sv
// Byte-command to Wishbone classic bridge.
//
//   state     | meaning
//   ----------+-----------------------------------------------------
//   IDLE      | waiting for a command byte
//   ADDR0..2  | collecting address bytes, MSB first
//   LEN       | collecting length byte L (L+1 transfers follow)
//   WDATA     | waiting for next write data byte
//   WBUS      | Wishbone write: one idle cycle, then strobe until ack/timeout
//   RBUS      | Wishbone read: one idle cycle, then strobe until ack/timeout
//   TXWAIT    | response byte presented, waiting for tx_ready
module wb_byte_master
  import wb_master_pkg::*;
#(
  parameter int unsigned timeout_cycles = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [0:7]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready,
  output logic [0:7]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic [0:23] wb_adr_o,
  output logic [0:7]  wb_dat_o,
  output logic        wb_we_o,
  output logic [0:0]  wb_sel_o,
  output logic        wb_stb_o,
  output logic        wb_cyc_o,
  input  logic [0:7]  wb_dat_i,
  input  logic        wb_ack_i,
  output logic        bus_error
);

  state_t      state, state_next;
  logic [23:0] addr_q;
  logic [7:0]  count_q, dat_q, tx_data_q;
  logic [3:0]  op_q;
  logic        cyc_q, we_q, tx_valid_q, rx_ready_q, bus_error_q;

  logic [7:0]  rx_byte, rd_byte;
  logic [3:0]  rx_op;
  logic        rx_fire, tx_fire, bus_start, bus_end, bus_tmo, tmo_expired;

  assign rx_byte = rx_data;
  assign rd_byte = wb_dat_i;
  assign rx_op   = rx_byte[7:4];

  wb_timeout_counter #(.timeout_cycles(timeout_cycles)) u_tmo (
    .clk     (clk),
    .reset   (reset),
    .load    (bus_start),
    .run     (cyc_q),
    .expired (tmo_expired)
  );

  // Next-state decode plus the per-cycle control strobes used by the datapath.
  always_comb begin
    state_next = state;
    rx_fire    = rx_valid && rx_ready_q;
    tx_fire    = tx_valid_q && tx_ready;
    bus_start  = 1'b0;
    bus_end    = cyc_q && (wb_ack_i || tmo_expired);
    bus_tmo    = cyc_q && !wb_ack_i && tmo_expired;
    case (state)
      ST_IDLE: begin
        if (rx_fire) begin
          case (rx_op)
            OP_SETADDR:          state_next = ST_ADDR0;
            OP_WRITE, OP_READ:   state_next = ST_LEN;
            OP_PING, OP_STATUS:  state_next = ST_TXWAIT;
            default:             state_next = ST_IDLE;
          endcase
        end
      end
      ST_ADDR0: if (rx_fire) state_next = ST_ADDR1;
      ST_ADDR1: if (rx_fire) state_next = ST_ADDR2;
      ST_ADDR2: if (rx_fire) state_next = ST_IDLE;
      ST_LEN:   if (rx_fire) state_next = (op_q == OP_READ) ? ST_RBUS : ST_WDATA;
      ST_WDATA: if (rx_fire) state_next = ST_WBUS;
      ST_WBUS: begin
        if (!cyc_q)       bus_start  = 1'b1;
        else if (bus_end) state_next = (count_q == 8'd0) ? ST_IDLE : ST_WDATA;
      end
      ST_RBUS: begin
        if (!cyc_q)       bus_start  = 1'b1;
        else if (bus_end) state_next = ST_TXWAIT;
      end
      ST_TXWAIT: begin
        if (tx_fire)
          state_next = (op_q == OP_READ && count_q != 8'd0) ? ST_RBUS : ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_next;
  end

  // Address/length/data registers, bus handshake and response path.
  always_ff @(posedge clk) begin
    if (reset) begin
      addr_q      <= 24'd0;
      count_q     <= 8'd0;
      dat_q       <= 8'd0;
      tx_data_q   <= 8'd0;
      op_q        <= 4'd0;
      cyc_q       <= 1'b0;
      we_q        <= 1'b0;
      tx_valid_q  <= 1'b0;
      rx_ready_q  <= 1'b0;
      bus_error_q <= 1'b0;
    end else begin
      we_q       <= (state_next == ST_WBUS);
      rx_ready_q <= accepts_rx(state_next);

      if (rx_fire) begin
        case (state)
          ST_IDLE: begin
            op_q <= rx_op;
            if (rx_op == OP_PING) begin
              tx_data_q  <= PING_RESP;
              tx_valid_q <= 1'b1;
            end else if (rx_op == OP_STATUS) begin
              tx_data_q  <= {bus_error_q, 7'b0};
              tx_valid_q <= 1'b1;
            end
          end
          ST_ADDR0: addr_q[23:16] <= rx_byte;
          ST_ADDR1: addr_q[15:8]  <= rx_byte;
          ST_ADDR2: addr_q[7:0]   <= rx_byte;
          ST_LEN:   count_q       <= rx_byte;
          ST_WDATA: dat_q         <= rx_byte;
          default: ;
        endcase
      end

      if (bus_start) cyc_q <= 1'b1;

      if (bus_end) begin
        cyc_q  <= 1'b0;
        addr_q <= addr_q + 24'd1;
        if (state == ST_RBUS) begin
          tx_data_q  <= wb_ack_i ? rd_byte : RD_TIMEOUT_DATA;
          tx_valid_q <= 1'b1;
        end
        if (state == ST_WBUS && count_q != 8'd0) count_q <= count_q - 8'd1;
      end

      if (tx_fire) begin
        tx_valid_q <= 1'b0;
        if (op_q == OP_READ && count_q != 8'd0) count_q <= count_q - 8'd1;
        if (op_q == OP_STATUS) bus_error_q <= 1'b0;
      end

      // A new timeout outranks a STATUS clear landing in the same cycle.
      if (bus_tmo) bus_error_q <= 1'b1;
    end
  end

  assign rx_ready  = rx_ready_q;
  assign tx_data   = tx_data_q;
  assign tx_valid  = tx_valid_q;
  assign wb_adr_o  = addr_q;
  assign wb_dat_o  = dat_q;
  assign wb_we_o   = we_q;
  assign wb_sel_o  = cyc_q;
  assign wb_stb_o  = cyc_q;
  assign wb_cyc_o  = cyc_q;
  assign bus_error = bus_error_q;

endmodule

// File: tb/tb_wb_byte_master.sv
// Directed bench for wb_byte_master with a one-cycle-ack Wishbone slave model.
module tb_wb_byte_master;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [0:7]  rx_data = 8'h00;
  logic        rx_valid = 1'b0;
  logic        rx_ready;
  logic [0:7]  tx_data;
  logic        tx_valid;
  logic        tx_ready = 1'b1;
  logic [0:23] wb_adr_o;
  logic [0:7]  wb_dat_o;
  logic        wb_we_o;
  logic [0:0]  wb_sel_o;
  logic        wb_stb_o;
  logic        wb_cyc_o;
  logic [0:7]  wb_dat_i;
  logic        wb_ack_i;
  logic        bus_error;

  wb_byte_master #(.timeout_cycles(8)) dut (
    .clk(clk), .reset(reset),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o), .wb_we_o(wb_we_o),
    .wb_sel_o(wb_sel_o), .wb_stb_o(wb_stb_o), .wb_cyc_o(wb_cyc_o),
    .wb_dat_i(wb_dat_i), .wb_ack_i(wb_ack_i), .bus_error(bus_error)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  logic        ack_en = 1'b1;
  logic [7:0]  rd_q[$];
  logic [24:0] bl_wa[$];
  logic [7:0]  bl_d[$];
  logic [7:0]  tx_log[$];
  int          stb_cycles = 0;
  int          sel_bad = 0;
  int          idle_bad = 0;
  logic        prev_stb = 1'b0;
  logic        prev_ack = 1'b0;

  typedef struct {
    string            name;
    int               nb;
    logic [0:7][7:0]  b;
    int               nrd;
    logic [0:2][7:0]  rd;
    int               nbus;
    logic [0:2][24:0] bus;   // {we, adr}
    logic [0:2][7:0]  bdat;
    int               ntx;
    logic [0:2][7:0]  tx;
  } vec_t;

  vec_t tv[6];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  // Slave: ack one cycle after seeing a strobe, returning queued read data.
  initial begin
    wb_ack_i = 1'b0;
    wb_dat_i = 8'h00;
    forever begin
      @(posedge clk);
      #1;
      if (ack_en && wb_cyc_o && wb_stb_o && !wb_ack_i) begin
        wb_ack_i = 1'b1;
        if (rd_q.size() > 0) wb_dat_i = rd_q.pop_front();
        else                 wb_dat_i = 8'hEE;
      end else begin
        wb_ack_i = 1'b0;
      end
    end
  end

  // Monitor: logs completed bus accesses and tx handshakes, tracks strobe rules.
  always @(negedge clk) begin
    if (!reset) begin
      if (wb_stb_o) stb_cycles++;
      if (wb_sel_o != wb_stb_o) sel_bad++;
      if (wb_stb_o && prev_stb && prev_ack) idle_bad++;
      if (wb_cyc_o && wb_stb_o && wb_ack_i) begin
        bl_wa.push_back({wb_we_o, wb_adr_o});
        bl_d.push_back(wb_dat_o);
      end
      if (tx_valid && tx_ready) tx_log.push_back(tx_data);
    end
    prev_stb = wb_stb_o;
    prev_ack = wb_ack_i;
  end

  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    @(negedge clk);
    rx_data  = b;
    rx_valid = 1'b1;
    while (!rx_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!rx_ready) begin
      n_cmp++;
      n_bad++;
      $display("FAIL rx_accept: byte %02h not accepted, rx_ready=0, expected 1", b);
    end else begin
      @(posedge clk);
    end
    #1 rx_valid = 1'b0;
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic clear_logs();
    bl_wa.delete();
    bl_d.delete();
    tx_log.delete();
  endtask

  function automatic vec_t mk(input string name, input int nb, input logic [0:7][7:0] b,
                              input int nrd, input logic [0:2][7:0] rd,
                              input int nbus, input logic [0:2][24:0] bus,
                              input logic [0:2][7:0] bdat,
                              input int ntx, input logic [0:2][7:0] tx);
    vec_t v;
    v.name = name; v.nb = nb; v.b = b; v.nrd = nrd; v.rd = rd;
    v.nbus = nbus; v.bus = bus; v.bdat = bdat; v.ntx = ntx; v.tx = tx;
    return v;
  endfunction

  task automatic run_vec(input vec_t v);
    clear_logs();
    rd_q.delete();
    for (int k = 0; k < v.nrd; k++) rd_q.push_back(v.rd[k]);
    for (int k = 0; k < v.nb; k++) send_byte(v.b[k]);
    wait_cycles(40);
    check({v.name, ".nbus"}, 32'(bl_wa.size()), 32'(v.nbus));
    for (int k = 0; k < v.nbus; k++) begin
      if (k < bl_wa.size()) begin
        check($sformatf("%s.we_adr%0d", v.name, k), 32'(bl_wa[k]), 32'(v.bus[k]));
        if (v.bus[k][24]) check($sformatf("%s.dat%0d", v.name, k), 32'(bl_d[k]), 32'(v.bdat[k]));
      end
    end
    check({v.name, ".ntx"}, 32'(tx_log.size()), 32'(v.ntx));
    for (int k = 0; k < v.ntx; k++)
      if (k < tx_log.size()) check($sformatf("%s.tx%0d", v.name, k), 32'(tx_log[k]), 32'(v.tx[k]));
    check({v.name, ".bus_error"}, 32'(bus_error), 32'd0);
  endtask

  initial begin
    int n;

    tv[0] = mk("wr_1000", 8, {8'h10, 8'h00, 8'h10, 8'h00, 8'h20, 8'h01, 8'hAB, 8'hCD},
               0, '0, 2, {25'h1001000, 25'h1001001, 25'h0}, {8'hAB, 8'hCD, 8'h00}, 0, '0);
    tv[1] = mk("rd_10000", 6, {8'h10, 8'h01, 8'h00, 8'h00, 8'h30, 8'h02, 8'h00, 8'h00},
               3, {8'h11, 8'h22, 8'h33}, 3, {25'h0010000, 25'h0010001, 25'h0010002}, '0,
               3, {8'h11, 8'h22, 8'h33});
    tv[2] = mk("wr_wrap", 8, {8'h10, 8'hFF, 8'hFF, 8'hFF, 8'h20, 8'h01, 8'h5A, 8'hC3},
               0, '0, 2, {25'h1FFFFFF, 25'h1000000, 25'h0}, {8'h5A, 8'hC3, 8'h00}, 0, '0);
    tv[3] = mk("rd_after_wrap", 2, {8'h30, 8'h00, 48'h0},
               1, {8'h77, 16'h0}, 1, {25'h0000001, 50'h0}, '0, 1, {8'h77, 16'h0});
    tv[4] = mk("ping", 1, {8'h40, 56'h0}, 0, '0, 0, '0, '0, 1, {8'hA5, 16'h0});
    tv[5] = mk("ignored_ops", 4, {8'h70, 8'h00, 8'hF3, 8'h40, 32'h0},
               0, '0, 0, '0, '0, 1, {8'hA5, 16'h0});

    // Reset state
    repeat (3) @(negedge clk);
    check("rst.cyc", 32'(wb_cyc_o), 32'd0);
    check("rst.stb", 32'(wb_stb_o), 32'd0);
    check("rst.we", 32'(wb_we_o), 32'd0);
    check("rst.sel", 32'(wb_sel_o), 32'd0);
    check("rst.adr", 32'(wb_adr_o), 32'd0);
    check("rst.dat", 32'(wb_dat_o), 32'd0);
    check("rst.tx_valid", 32'(tx_valid), 32'd0);
    check("rst.tx_data", 32'(tx_data), 32'd0);
    check("rst.rx_ready", 32'(rx_ready), 32'd0);
    check("rst.bus_error", 32'(bus_error), 32'd0);
    reset = 1'b0;
    @(negedge clk);
    check("rst.rx_ready_after", 32'(rx_ready), 32'd1);

    for (int i = 0; i < 6; i++) run_vec(tv[i]);

    // Read with no ack: 8-cycle strobe, 0xFF returned, sticky error, STATUS clears
    ack_en = 1'b0;
    clear_logs();
    send_byte(8'h30);
    stb_cycles = 0;
    send_byte(8'h00);
    wait_cycles(40);
    check("tmo.stb_cycles", 32'(stb_cycles), 32'd8);
    check("tmo.nbus", 32'(bl_wa.size()), 32'd0);
    check("tmo.ntx", 32'(tx_log.size()), 32'd1);
    if (tx_log.size() > 0) check("tmo.tx", 32'(tx_log[0]), 32'hFF);
    check("tmo.bus_error", 32'(bus_error), 32'd1);
    ack_en = 1'b1;
    clear_logs();
    send_byte(8'h50);
    wait_cycles(10);
    check("status1.ntx", 32'(tx_log.size()), 32'd1);
    if (tx_log.size() > 0) check("status1.tx", 32'(tx_log[0]), 32'h80);
    check("status1.bus_error", 32'(bus_error), 32'd0);
    clear_logs();
    send_byte(8'h50);
    wait_cycles(10);
    check("status2.ntx", 32'(tx_log.size()), 32'd1);
    if (tx_log.size() > 0) check("status2.tx", 32'(tx_log[0]), 32'h00);

    // Address advanced past the timed-out access
    clear_logs();
    rd_q.delete();
    rd_q.push_back(8'h9A);
    send_byte(8'h30);
    send_byte(8'h00);
    wait_cycles(20);
    check("post_tmo.nbus", 32'(bl_wa.size()), 32'd1);
    if (bl_wa.size() > 0) check("post_tmo.adr", 32'(bl_wa[0]), 32'h0000003);
    check("post_tmo.ntx", 32'(tx_log.size()), 32'd1);
    if (tx_log.size() > 0) check("post_tmo.tx", 32'(tx_log[0]), 32'h9A);

    // PING held off by tx_ready low for 20 cycles
    @(posedge clk);
    #1 tx_ready = 1'b0;
    clear_logs();
    send_byte(8'h40);
    n = 0;
    while (!tx_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      check($sformatf("hold%0d.tx_valid", c), 32'(tx_valid), 32'd1);
      check($sformatf("hold%0d.tx_data", c), 32'(tx_data), 32'hA5);
      check($sformatf("hold%0d.rx_ready", c), 32'(rx_ready), 32'd0);
    end
    check("hold.no_bus", 32'(bl_wa.size()), 32'd0);
    @(posedge clk);
    #1 tx_ready = 1'b1;
    wait_cycles(5);
    check("hold.ntx", 32'(tx_log.size()), 32'd1);
    if (tx_log.size() > 0) check("hold.tx", 32'(tx_log[0]), 32'hA5);

    // Reset while a strobe waits for ack
    ack_en = 1'b0;
    rd_q.delete();
    send_byte(8'h10);
    send_byte(8'h12);
    send_byte(8'h34);
    send_byte(8'h56);
    send_byte(8'h30);
    send_byte(8'h00);
    n = 0;
    while (!wb_stb_o && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("mid_rst.stb_seen", 32'(wb_stb_o), 32'd1);
    check("mid_rst.adr_before", 32'(wb_adr_o), 32'h123456);
    reset = 1'b1;
    @(negedge clk);
    check("mid_rst.cyc", 32'(wb_cyc_o), 32'd0);
    check("mid_rst.stb", 32'(wb_stb_o), 32'd0);
    check("mid_rst.adr", 32'(wb_adr_o), 32'd0);
    check("mid_rst.tx_valid", 32'(tx_valid), 32'd0);
    check("mid_rst.rx_ready", 32'(rx_ready), 32'd0);
    ack_en = 1'b1;
    reset = 1'b0;
    @(negedge clk);
    check("mid_rst.rx_ready_after", 32'(rx_ready), 32'd1);
    clear_logs();
    rd_q.push_back(8'h3C);
    send_byte(8'h30);
    send_byte(8'h00);
    wait_cycles(20);
    check("mid_rst.nbus", 32'(bl_wa.size()), 32'd1);
    if (bl_wa.size() > 0) check("mid_rst.read_adr", 32'(bl_wa[0]), 32'h0000000);
    check("mid_rst.ntx", 32'(tx_log.size()), 32'd1);
    if (tx_log.size() > 0) check("mid_rst.tx", 32'(tx_log[0]), 32'h3C);
    check("mid_rst.bus_error", 32'(bus_error), 32'd0);

    check("sel_follows_stb", 32'(sel_bad), 32'd0);
    check("stb_idle_gap", 32'(idle_bad), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/wb_byte_master.md
WB_BYTE_MASTER -- requirements
Module: wb_byte_master

Interface
REQ-001 SHALL have parameter timeout_cycles, default 255, meaning ack wait limit in clk cycles per bus access (1..255).
REQ-002 SHALL have port clk  input  1  system clock.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port rx_data  input  [0:7]  command/data byte from host stream.
REQ-005 SHALL have port rx_valid  input  1  rx_data valid.
REQ-006 SHALL have port rx_ready  output  1  byte accepted when rx_valid && rx_ready at clk edge.
REQ-007 SHALL have port tx_data  output  [0:7]  response byte to host.
REQ-008 SHALL have port tx_valid  output  1  tx_data valid; held with tx_data stable until tx_ready.
REQ-009 SHALL have port tx_ready  input  1  host accepts tx_data.
REQ-010 SHALL have ports wb_adr_o [0:23], wb_dat_o [0:7], wb_we_o 1, wb_sel_o [0:0], wb_stb_o 1, wb_cyc_o 1 (outputs), and wb_dat_i [0:7], wb_ack_i 1 (inputs): Wishbone classic initiator.
REQ-011 SHALL have port bus_error  output  1  sticky timeout flag.

Function
REQ-012 SHALL decode command byte upper nibble: 0x1 SETADDR, 0x2 WRITE, 0x3 READ, 0x4 PING, 0x5 STATUS; other opcodes consumed, ignored, no response.
REQ-013 SETADDR SHALL consume 3 following bytes, MSB first, into 24-bit address register.
REQ-014 WRITE SHALL consume length byte L, then L+1 data bytes; each byte triggers one Wishbone write at current address, then address += 1.
REQ-015 READ SHALL consume length byte L, then perform L+1 Wishbone reads, each returned byte sent on tx before next read starts; address += 1 after each.
REQ-016 PING SHALL send 0xA5; STATUS SHALL send {bus_error, 7'b0} and clear bus_error on tx handshake.
REQ-017 Address increment SHALL wrap 0xFFFFFF -> 0x000000.
REQ-018 FSM states SHALL be IDLE, ADDR0, ADDR1, ADDR2, LEN, WDATA, WBUS, RBUS, TXWAIT; RESP reused via TXWAIT for PING/STATUS.
REQ-019 rx_ready SHALL be 1 only in IDLE, ADDR0-2, LEN, WDATA; 0 during bus cycles and TXWAIT.
REQ-020 Bus cycle: wb_cyc_o, wb_stb_o asserted together the cycle after entering WBUS/RBUS, held until wb_ack_i sampled high, deasserted the following cycle; wb_sel_o = 1 whenever stb high.
REQ-021 wb_we_o SHALL be 1 in WBUS, 0 in RBUS; wb_adr_o and wb_dat_o stable for whole cycle.
REQ-022 READ SHALL capture wb_dat_i on the ack cycle.
REQ-023 Timeout counter SHALL reset at cycle start; if timeout_cycles elapse without ack, SHALL end cycle, set bus_error, use 0xFF as read data, and continue sequence (address still increments).
REQ-024 bus_error set and STATUS clear in same cycle SHALL leave bus_error set.
REQ-025 tx_valid SHALL stay high until tx_ready; no new bus cycle while tx_valid pending.
REQ-026 At most one bus access outstanding; minimum 1 idle clk between successive strobes.

Reset
REQ-027 On reset: FSM IDLE, address 0x000000, count 0, bus_error 0, wb_cyc_o/wb_stb_o/wb_we_o 0, wb_sel_o 0, wb_adr_o 0, wb_dat_o 0x00, tx_valid 0, tx_data 0x00, rx_ready 0.
REQ-028 Reset mid-transaction SHALL drop cyc/stb next edge; pending ack ignored; partial command discarded.
REQ-029 rx_ready SHALL go 1 the first cycle after reset deasserts.

Structure
REQ-030 Opcode constants and state encoding SHALL live in shared package wb_master_pkg.
REQ-031 Single module; optional sub-module wb_timeout_counter for REQ-023.

Verification
REQ-032 Bytes 0x10,0x00,0x10,0x00 then 0x20,0x01,0xAB,0xCD -> writes 0xAB@0x001000, 0xCD@0x001001, we=1, sel=1.
REQ-033 SETADDR 0x01,0x00,0x00; READ 0x30,0x02 with slave data 0x11,0x22,0x33 -> tx 0x11,0x22,0x33 from 0x010000..0x010002.
REQ-034 SETADDR 0xFF,0xFF,0xFF; WRITE L=1 -> writes at 0xFFFFFF then 0x000000.
REQ-035 READ L=0 with no ack, timeout_cycles=8 -> cyc/stb high 8 cycles, tx 0xFF, bus_error=1; STATUS -> tx 0x80, bus_error=0; STATUS again -> 0x00.
REQ-036 PING with tx_ready low 20 cycles -> tx_valid held, tx_data 0xA5 stable, rx_ready 0; opcode 0x70 -> no tx, no bus cycle.
REQ-037 Reset asserted while stb high awaiting ack -> cyc/stb 0 next cycle, FSM IDLE, address 0.
